z80_mcycle_fsm: RTL

- Generalised machine-cycle sequencer for the z80 control path.
- Executes one complete machine cycle per start request: opcode fetch (OCF), memory read (MR), memory write (MW), port read (PR) or port write (PW).
- Produces the bus strobes and address/data enables, and honours WAIT_L.
- Inserts a parametrised number of automatic I/O wait states and maintains the refresh (R) register during OCF.
- control_fsm instantiates one of these and issues cycle requests to it from decode.

---
 rtl/z80_mcycle_fsm_if.sv | 42 ++++
 rtl/z80_mcycle_fsm.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/z80_mcycle_fsm_if.sv
// Bus bundle between the z80 control path and the machine-cycle sequencer.
// The master issues cycle requests and the slave (sequencer) drives the bus strobes.
interface z80_mcycle_fsm_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              start;
    logic [2:0]        cyc_type;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata;
    logic [7:0]        i_reg;
    logic              r_load;
    logic [7:0]        r_wdata;
    logic [DATA_W-1:0] data_in;
    logic              WAIT_L;

    logic              ready;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic [7:0]        r_out;
    logic              M1_L;
    logic              MREQ_L;
    logic              IORQ_L;
    logic              RD_L;
    logic              WR_L;
    logic              RFSH_L;

    modport master (
        output start, cyc_type, addr_in, wdata, i_reg, r_load, r_wdata, data_in, WAIT_L,
        input  ready, done, rdata, addr_out, data_out, data_oe, r_out,
               M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L
    );

    modport slave (
        input  start, cyc_type, addr_in, wdata, i_reg, r_load, r_wdata, data_in, WAIT_L,
        output ready, done, rdata, addr_out, data_out, data_oe, r_out,
               M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L
    );
endinterface

// File: rtl/z80_mcycle_fsm.sv
// Machine-cycle sequencer: runs one OCF/MR/MW/PR/PW cycle per accepted start,
// with WAIT_L stretching, automatic I/O wait states and R-register refresh.
//
// state | meaning
// IDLE  | no cycle in progress, ready for start
// T1    | first T-state, address driven
// T2    | strobes active, WAIT_L sampled on exit (non-I/O or IO_WAIT=0)
// TA    | automatic I/O wait, WAIT_L sampled on exit of the last one
// TW    | external wait while WAIT_L=0 is sampled
// T3    | data captured on entry; final state except for OCF (refresh)
// T4    | OCF refresh tail, final state, R increments on exit
module z80_mcycle_fsm #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned IO_WAIT = 1,
    parameter int unsigned R_W     = 7
) (
    input logic             clk_i,
    input logic             rst_i,
    z80_mcycle_fsm_if.slave bus_if
);

    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_TA, S_TW, S_T3, S_T4
    } state_e;

    typedef enum logic [2:0] {
        CY_OCF = 3'd0,
        CY_MR  = 3'd1,
        CY_MW  = 3'd2,
        CY_PR  = 3'd3,
        CY_PW  = 3'd4
    } cyc_e;

    localparam bit         HAS_TA  = (IO_WAIT != 0);
    localparam logic [2:0] TA_LAST = 3'(IO_WAIT - 1);
    localparam logic [7:0] R_MASK  = 8'((1 << R_W) - 1);

    state_e            state_q, state_d;
    cyc_e              type_q, type_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [7:0]        r_q, r_d;
    logic [2:0]        ta_cnt_q, ta_cnt_d;

    logic m1_l, mreq_l, iorq_l, rd_l, wr_l, rfsh_l;
    logic data_oe, done, ready;
    logic start_ok, enter_t3, is_io, is_read;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            type_q   <= CY_OCF;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            r_q      <= '0;
            ta_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            r_q      <= r_d;
            ta_cnt_q <= ta_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        r_d      = r_q;
        ta_cnt_d = ta_cnt_q;

        m1_l     = 1'b1;
        mreq_l   = 1'b1;
        iorq_l   = 1'b1;
        rd_l     = 1'b1;
        wr_l     = 1'b1;
        rfsh_l   = 1'b1;
        data_oe  = 1'b0;
        done     = 1'b0;
        ready    = 1'b0;
        enter_t3 = 1'b0;

        is_io    = (type_q == CY_PR) || (type_q == CY_PW);
        is_read  = (type_q == CY_OCF) || (type_q == CY_MR) || (type_q == CY_PR);
        start_ok = bus_if.start && (bus_if.cyc_type <= 3'd4);

        case (state_q)
            S_IDLE: ready = 1'b1;
            S_T1: begin
                state_d = S_T2;
                case (type_q)
                    CY_OCF:  begin m1_l = 1'b0; mreq_l = 1'b0; rd_l = 1'b0; end
                    CY_MR:   begin mreq_l = 1'b0; rd_l = 1'b0; end
                    CY_MW:   begin mreq_l = 1'b0; data_oe = 1'b1; end
                    CY_PW:   data_oe = 1'b1;
                    default: ;
                endcase
            end
            S_T2, S_TA, S_TW: begin
                case (type_q)
                    CY_OCF:  begin m1_l = 1'b0; mreq_l = 1'b0; rd_l = 1'b0; end
                    CY_MR:   begin mreq_l = 1'b0; rd_l = 1'b0; end
                    CY_MW:   begin mreq_l = 1'b0; wr_l = 1'b0; data_oe = 1'b1; end
                    CY_PR:   begin iorq_l = 1'b0; rd_l = 1'b0; end
                    CY_PW:   begin iorq_l = 1'b0; wr_l = 1'b0; data_oe = 1'b1; end
                    default: ;
                endcase
                // WAIT_L is ignored on T2 exit when automatic I/O waits follow
                if (state_q == S_T2 && is_io && HAS_TA) begin
                    state_d  = S_TA;
                    ta_cnt_d = TA_LAST;
                end else if (state_q == S_TA && ta_cnt_q != 3'd0) begin
                    ta_cnt_d = ta_cnt_q - 3'd1;
                end else if (!bus_if.WAIT_L) begin
                    state_d = S_TW;
                end else begin
                    enter_t3 = 1'b1;
                end
            end
            S_T3: begin
                if (type_q == CY_OCF) begin
                    mreq_l  = 1'b0;
                    rfsh_l  = 1'b0;
                    state_d = S_T4;
                end else begin
                    done    = 1'b1;
                    ready   = 1'b1;
                    data_oe = (type_q == CY_MW) || (type_q == CY_PW);
                end
            end
            S_T4: begin
                rfsh_l = 1'b0;
                done   = 1'b1;
                ready  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_t3) begin
            state_d = S_T3;
            if (is_read) begin
                rdata_d = bus_if.data_in;
            end
            if (type_q == CY_OCF) begin
                addr_d = ADDR_W'({bus_if.i_reg, r_q});
            end
        end

        // Final states chain straight into T1 so back-to-back cycles have no gap
        if (ready) begin
            state_d = S_IDLE;
            if (start_ok) begin
                state_d = S_T1;
                type_d  = cyc_e'(bus_if.cyc_type);
                addr_d  = bus_if.addr_in;
                wdata_d = bus_if.wdata;
            end
        end

        if (state_q == S_T4) begin
            r_d = (r_q & ~R_MASK) | ((r_q + 8'd1) & R_MASK);
        end
        if (bus_if.r_load) begin
            r_d = bus_if.r_wdata;
        end
    end

    assign bus_if.ready    = ready;
    assign bus_if.done     = done;
    assign bus_if.rdata    = rdata_q;
    assign bus_if.addr_out = addr_q;
    assign bus_if.data_out = wdata_q;
    assign bus_if.data_oe  = data_oe;
    assign bus_if.r_out    = r_q;
    assign bus_if.M1_L     = m1_l;
    assign bus_if.MREQ_L   = mreq_l;
    assign bus_if.IORQ_L   = iorq_l;
    assign bus_if.RD_L     = rd_l;
    assign bus_if.WR_L     = wr_l;
    assign bus_if.RFSH_L   = rfsh_l;

endmodule
